// File: rtl/dii_pkg.sv
// DII flit definitions shared by the debug ring router blocks.
//   dii_flit_t : one flit on a DII channel (payload plus worm markers).
//                A channel carries this flit plus a valid/ready handshake.
package dii_pkg;

  localparam int DII_DATA_W = 16;

  typedef struct packed {
    logic [DII_DATA_W-1:0] data;
    logic                  first;  // header flit of a worm; data holds the destination
    logic                  last;   // final flit of a worm
  } dii_flit_t;

endpackage

// File: rtl/ring_router_pkg.sv
// Shared definitions for the debug ring router.
//   demux_state_t     : worm tracking state of the ingress demux
//   DEST_LSB/DEST_MSB : location of the destination field in a header flit
package ring_router_pkg;

  localparam int DEST_LSB = 0;
  localparam int DEST_MSB = 15;

  // IDLE       : no worm open; the next head must be a header flit
  // WORM_LOCAL : a worm to this node is open; body flits go to the local port
  // WORM_RING  : a worm to another node is open; body flits go back on the ring
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WORM_LOCAL = 2'd1,
    WORM_RING  = 2'd2
  } demux_state_t;

endpackage

// File: rtl/dii_fifo_small.sv
// Small DII flit buffer with a registered not-full flag.
//   clk, rst   : clock, synchronous active-high reset (flushes the buffer)
//   push_flit  : flit to store
//   push       : push request; honoured only while not_full is high
//   not_full   : registered (count < DEPTH); usable directly as a ready
//   pop        : remove the head entry; ignored while empty
//   head       : oldest entry; only meaningful while count != 0
//   count      : number of stored entries
// DEPTH must be a power of two (2 or 4) so the pointers wrap for free.
// With DEPTH = 2 a push and a pop in every cycle keep count at 1, so the
// registered not-full flag never costs throughput.
module dii_fifo_small
  import dii_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  dii_flit_t                  push_flit,
  input  logic                       push,
  output logic                       not_full,
  input  logic                       pop,
  output dii_flit_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  dii_flit_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  // not_full reflects the count at the start of the cycle, so a pop in a
  // full cycle does not open a slot until the next cycle.
  assign do_push = push & not_full;
  assign do_pop  = pop & (count != '0);

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count_nxt;
      not_full <= (count_nxt < CW'(DEPTH));
    end
  end

  // Storage needs no reset: entries are only read once count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_flit;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ring_router_demux.sv
// Ingress stage of the debug ring router, ahead of the router output mux.
// Buffers ring flits, routes each worm by the destination in its header
// flit, keeps every worm on one output and drops orphan flits.
//   clk, rst        : clock, synchronous active-high reset
//   id              : this node's address; change only while no worm is open
//   in_*            : flits from the ring (data/first/last/valid, ready back)
//   out_local_*     : worms whose destination equals id
//   out_ring_*      : all other worms, towards the mux ring input
//   err_orphan      : one-cycle pulse per dropped orphan flit, and per
//                     header flit that arrives inside an open worm
// Both output channels are decoded from the buffer head and the state
// register only, so no output valid or data depends on a same-cycle input.
module ring_router_demux
  import dii_pkg::*;
  import ring_router_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,

  input  logic [15:0] in_data,
  input  logic        in_first,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,

  output logic [15:0] out_local_data,
  output logic        out_local_first,
  output logic        out_local_last,
  output logic        out_local_valid,
  input  logic        out_local_ready,

  output logic [15:0] out_ring_data,
  output logic        out_ring_first,
  output logic        out_ring_last,
  output logic        out_ring_valid,
  input  logic        out_ring_ready,

  output logic        err_orphan
);

  dii_flit_t                  in_flit;
  dii_flit_t                  head;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       head_valid;
  logic                       is_local_dest;
  logic                       new_worm;
  logic                       orphan_drop;
  logic                       sel_local;
  logic                       pop;
  demux_state_t               state;

  assign in_flit = '{data: in_data, first: in_first, last: in_last};

  dii_fifo_small #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_flit (in_flit),
    .push      (in_valid),
    .not_full  (in_ready),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign head_valid    = (count != '0);
  assign is_local_dest = (head.data[DEST_MSB:DEST_LSB] == id);

  // Routing of the head flit.
  // A header flit always opens a fresh worm, even inside an open one, so a
  // truncated worm cannot swallow the next good worm. Body flits follow the
  // open worm; outside a worm they are orphans and are dropped at once,
  // independent of either output's ready, so they never block the input.
  always_comb begin
    new_worm        = head_valid & head.first;
    orphan_drop     = head_valid & ~head.first & (state == IDLE);
    sel_local       = new_worm ? is_local_dest : (state == WORM_LOCAL);
    out_local_valid = head_valid & ~orphan_drop & sel_local;
    out_ring_valid  = head_valid & ~orphan_drop & ~sel_local;
    pop             = orphan_drop
                    | (out_local_valid & out_local_ready)
                    | (out_ring_valid  & out_ring_ready);
    // The in-worm header is flagged on its pop so a stalled header still
    // gives exactly one pulse.
    err_orphan      = orphan_drop | (new_worm & (state != IDLE) & pop);
  end

  // Payload goes to both ports; only the selected one raises valid.
  assign out_local_data  = head.data;
  assign out_local_first = head.first;
  assign out_local_last  = head.last;
  assign out_ring_data   = head.data;
  assign out_ring_first  = head.first;
  assign out_ring_last   = head.last;

  // The state only moves when a routed flit is actually taken, so a stalled
  // header keeps its routing decision (and its output) stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (pop && !orphan_drop) begin
      if (head.last)     state <= IDLE;
      else if (sel_local) state <= WORM_LOCAL;
      else                state <= WORM_RING;
    end
  end

endmodule
